// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_arbiter_pkg: shared owner encodings, count-width helper and vc-MemMsg size macros
// No ports. OWNER_IMEM/OWNER_DMEM tag each owner-FIFO entry; cnt_w(n) gives the width of an occupancy count 0..n.
`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_,d_) (1+(a_)+$clog2((d_)/8)+(d_))
`endif
`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d_) (1+$clog2((d_)/8)+(d_))
`endif
package riscv_mem_arbiter_pkg;
  localparam logic OWNER_IMEM = 1'b0;
  localparam logic OWNER_DMEM = 1'b1;
  function automatic int cnt_w(int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: one vc-MemReqMsg/vc-MemRespMsg port
// master drives req_msg/req_val and receives req_rdy/resp_msg/resp_val; slave is the mirror.
interface riscv_mem_arbiter_if #(parameter int ADDR_SZ = 32, parameter int DATA_SZ = 32);
  logic [`VC_MEM_REQ_MSG_SZ(ADDR_SZ,DATA_SZ)-1:0] req_msg;
  logic                                           req_val;
  logic                                           req_rdy;
  logic [`VC_MEM_RESP_MSG_SZ(DATA_SZ)-1:0]        resp_msg;
  logic                                           resp_val;
  modport master(output req_msg, req_val, input req_rdy, resp_msg, resp_val);
  modport slave(input req_msg, req_val, output req_rdy, resp_msg, resp_val);
endinterface

// File: rtl/riscv_mem_arb_owner_fifo.sv
// riscv_mem_arb_owner_fifo: 1-bit in-order owner FIFO, DEPTH entries, async active-low reset
// Ports: clk, reset (active-low), push/din, pop, head, count (0..DEPTH), full, empty.
module riscv_mem_arb_owner_fifo
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     head,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rp];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between the instruction and data ports of riscv_Core
// Ports: clk, reset (async active-low), imem/dmem (slave side of the core ports), mem (master side
// toward memory), outst_count (owner-FIFO occupancy), err_unexp_resp (sticky response-while-empty).
// Build option RISCV_MEMARB_DPRIO_EN: dmem wins every tie instead of round-robin.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_SZ   = 32,
  parameter int DATA_SZ   = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  riscv_mem_arbiter_if.slave           imem,
  riscv_mem_arbiter_if.slave           dmem,
  riscv_mem_arbiter_if.master          mem,
  output logic [cnt_w(MAX_OUTST)-1:0]  outst_count,
  output logic                         err_unexp_resp
);
  localparam int RQ = `VC_MEM_REQ_MSG_SZ(ADDR_SZ,DATA_SZ);
  localparam int RS = `VC_MEM_RESP_MSG_SZ(DATA_SZ);
  logic          full, empty, head, locked, lock_own, tie, gnt, req_val, hs, rv;
  logic [RQ-1:0] sel_msg;
  logic [RS-1:0] resp_msg;
`ifdef RISCV_MEMARB_DPRIO_EN
  assign tie = OWNER_DMEM;
`else
  logic last;
  assign tie = ~last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last <= OWNER_IMEM;
    else if (hs) last <= gnt;
`endif
  // A stalled grant is held only while its requester keeps val up, so a dropped request cannot wedge the port.
  always_comb begin
    gnt      = (locked && (lock_own ? dmem.req_val : imem.req_val)) ? lock_own
             : (imem.req_val && dmem.req_val) ? tie : dmem.req_val;
    req_val  = (imem.req_val | dmem.req_val) & ~full;
    hs       = req_val & mem.req_rdy;
    rv       = mem.resp_val & ~empty;
    sel_msg  = gnt ? dmem.req_msg : imem.req_msg;
    resp_msg = reset ? mem.resp_msg : '0;
  end
  assign mem.req_msg    = reset ? sel_msg : '0;
  assign mem.req_val    = reset & req_val;
  assign imem.req_rdy   = reset & mem.req_rdy & ~full & (gnt == OWNER_IMEM);
  assign dmem.req_rdy   = reset & mem.req_rdy & ~full & (gnt == OWNER_DMEM);
  assign imem.resp_msg  = resp_msg;
  assign dmem.resp_msg  = resp_msg;
  assign imem.resp_val  = reset & rv & (head == OWNER_IMEM);
  assign dmem.resp_val  = reset & rv & (head == OWNER_DMEM);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      locked         <= 1'b0;
      lock_own       <= OWNER_IMEM;
      err_unexp_resp <= 1'b0;
    end else begin
      locked         <= req_val & ~mem.req_rdy;
      lock_own       <= gnt;
      err_unexp_resp <= err_unexp_resp | (mem.resp_val & empty);
    end
  riscv_mem_arb_owner_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (hs),
    .din   (gnt),
    .pop   (rv),
    .head  (head),
    .count (outst_count),
    .full  (full),
    .empty (empty)
  );
endmodule
